// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants, state encoding and writeback payload for the multdiv sequencer.
package multdiv_sequencer_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 40;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned REG_W           = 5;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL   = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;

  localparam logic [XLEN-1:0]  MUL_EXC     = 32'd4;
  localparam logic [XLEN-1:0]  DIV_EXC     = 32'd5;
  localparam logic [REG_W-1:0] REG_RSTATUS = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } pw_payload_t;

  // True for an R-type instruction whose ALU op selects the multdiv unit.
  function automatic logic is_md_op(input logic [XLEN-1:0] ir);
    return (ir[31:27] == OPC_RTYPE) && ((ir[6:2] == ALU_MUL) || (ir[6:2] == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Pipeline-side bundle of the multdiv sequencer: DX instruction, multdiv handshake, stall and PW port.
interface multdiv_sequencer_if;
  import multdiv_sequencer_pkg::*;

  logic [XLEN-1:0]  DX_IR;
  logic             md_resultRDY;
  logic             md_exception;
  logic [XLEN-1:0]  md_result;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             md_stall;
  logic             md_bubble;
  logic             md_busy;
  logic             PW_write;
  logic [REG_W-1:0] PW_rd;
  logic [XLEN-1:0]  PW_data;

  modport master (
    output DX_IR, md_resultRDY, md_exception, md_result,
    input  ctrl_MULT, ctrl_DIV, md_stall, md_bubble, md_busy, PW_write, PW_rd, PW_data
  );

  modport slave (
    input  DX_IR, md_resultRDY, md_exception, md_result,
    output ctrl_MULT, ctrl_DIV, md_stall, md_bubble, md_busy, PW_write, PW_rd, PW_data
  );

endinterface

// File: rtl/md_timeout_counter.sv
// Saturating BUSY-cycle counter; hit flags that the multdiv unit has run TIMEOUT cycles.
module md_timeout_counter #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over enable; holding at CNT_MAX keeps the count from wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit = (cnt_q == CNT_MAX);

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues mul/div from DX to the multdiv unit, stalls the front end until the result
// returns, then writes the result (or the exception code into r30) through the PW port.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_n,
  multdiv_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic             op_div_q;
  logic [REG_W-1:0] rd_q;
  pw_payload_t      pw_q, pw_d;

  logic dx_is_md, dx_is_div, issue;
  logic ctrl_mult_c, ctrl_div_c, stall_c, bubble_c;
  logic capture_c, pw_load_c, cnt_clear_c, cnt_en_c, cnt_hit;
  logic unused_ir;

  assign dx_is_md  = is_md_op(bus.DX_IR);
  assign dx_is_div = (bus.DX_IR[6:2] == ALU_DIV);
  // Gated by reset so a held md op in DX cannot pulse a start while reset is asserted.
  assign issue     = dx_is_md && reset_n;
  assign unused_ir = ^{bus.DX_IR[21:7], bus.DX_IR[1:0]};

  md_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clock),
    .rst_n  (reset_n),
    .clear  (cnt_clear_c),
    .enable (cnt_en_c),
    .hit    (cnt_hit)
  );

  // Next-state and control decode; counter runs from the issue cycle so it reads 1 in BUSY cycle 1.
  always_comb begin
    state_d     = state_q;
    ctrl_mult_c = 1'b0;
    ctrl_div_c  = 1'b0;
    stall_c     = 1'b0;
    bubble_c    = 1'b0;
    capture_c   = 1'b0;
    pw_load_c   = 1'b0;
    pw_d        = pw_q;
    cnt_clear_c = 1'b1;
    cnt_en_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          ctrl_mult_c = ~dx_is_div;
          ctrl_div_c  = dx_is_div;
          stall_c     = 1'b1;
          bubble_c    = 1'b1;
          capture_c   = 1'b1;
          cnt_clear_c = 1'b0;
          cnt_en_c    = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_c     = 1'b1;
        bubble_c    = 1'b1;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b1;
        if (bus.md_resultRDY || cnt_hit) begin
          pw_load_c = 1'b1;
          state_d   = ST_DONE;
          // RDY has priority; timeout alone takes the exception path.
          if (bus.md_resultRDY && !bus.md_exception) begin
            pw_d = '{rd: rd_q, data: bus.md_result};
          end else begin
            pw_d = '{rd: REG_RSTATUS, data: (op_div_q ? DIV_EXC : MUL_EXC)};
          end
        end
      end
      ST_DONE: begin
        bubble_c = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_div_q <= 1'b0;
      rd_q     <= '0;
      pw_q     <= '0;
    end else begin
      state_q <= state_d;
      if (capture_c) begin
        op_div_q <= dx_is_div;
        rd_q     <= bus.DX_IR[26:22];
      end
      if (pw_load_c) begin
        pw_q <= pw_d;
      end
    end
  end

  assign bus.ctrl_MULT = ctrl_mult_c;
  assign bus.ctrl_DIV  = ctrl_div_c;
  assign bus.md_stall  = stall_c;
  assign bus.md_bubble = bubble_c;
  assign bus.md_busy   = (state_q != ST_IDLE);
  // r0 is hardwired; only the exception path can target a nonzero rd when the latched rd is 0.
  assign bus.PW_write  = (state_q == ST_DONE) && (pw_q.rd != '0);
  assign bus.PW_rd     = pw_q.rd;
  assign bus.PW_data   = pw_q.data;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: table of md transactions plus hang, late-RDY and reset sequences.
module tb_multdiv_sequencer;

  localparam int unsigned TIMEOUT = 40;

  logic clock;
  logic reset_n;

  multdiv_sequencer_if md_if();

  multdiv_sequencer #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (md_if)
  );

  typedef struct {
    bit          div;
    logic [4:0]  rd;
    int          k;          // RDY at issue+k; 0 = never
    bit          exc;
    bit          early_rdy;  // RDY pulse in the issue cycle
    bit          noise;      // exception high on BUSY cycles without RDY
    logic [31:0] res;
    int          gap;
    logic [31:0] gap_ir;
    int          exp_stall;
    bit          exp_write;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [10];
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  prev_rd;
  logic [31:0] prev_data;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input bit div, input logic [4:0] rd, input int k, input bit exc,
                              input bit early, input bit noise, input logic [31:0] res,
                              input int gap, input logic [31:0] gap_ir, input int exp_stall,
                              input bit exp_write, input logic [4:0] exp_rd, input logic [31:0] exp_data);
    vec_t v;
    v.div = div; v.rd = rd; v.k = k; v.exc = exc; v.early_rdy = early; v.noise = noise;
    v.res = res; v.gap = gap; v.gap_ir = gap_ir; v.exp_stall = exp_stall;
    v.exp_write = exp_write; v.exp_rd = exp_rd; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic logic [31:0] enc(input bit div, input logic [4:0] rd);
    return {5'b00000, rd, 15'h0000, (div ? 5'b00111 : 5'b00110), 2'b00};
  endfunction

  // {ctrl_MULT, ctrl_DIV, md_stall, md_bubble, md_busy, PW_write}
  function automatic logic [5:0] ctl();
    return {md_if.ctrl_MULT, md_if.ctrl_DIV, md_if.md_stall, md_if.md_bubble,
            md_if.md_busy, md_if.PW_write};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int stalls;
    bit done;
    for (int g = 0; g < v.gap; g++) begin
      @(posedge clock); #1;
      md_if.DX_IR        = v.gap_ir;
      md_if.md_resultRDY = 1'b0;
      md_if.md_exception = 1'b0;
      #1;
      check("idle_ctl", 32'(ctl()), 32'h0);
      check("idle_pw_rd", 32'(md_if.PW_rd), 32'(prev_rd));
      check("idle_pw_data", md_if.PW_data, prev_data);
    end
    @(posedge clock); #1;
    md_if.DX_IR        = enc(v.div, v.rd);
    md_if.md_resultRDY = v.early_rdy;
    md_if.md_exception = v.early_rdy;
    md_if.md_result    = 32'hBAD0_BAD0;
    #1;
    check("issue_ctl", 32'(ctl()), 32'({~v.div, v.div, 4'b1100}));
    stalls = 1;
    done   = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clock); #1;
      md_if.md_resultRDY = (v.k != 0) && (j == v.k);
      md_if.md_exception = md_if.md_resultRDY ? v.exc : v.noise;
      md_if.md_result    = md_if.md_resultRDY ? v.res : 32'hBAD0_BAD0;
      #1;
      if (!md_if.md_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      check("busy_ctl", 32'(ctl()), 32'h0000_000E);
    end
    check("done_reached", 32'(done), 32'h1);
    check("stall_cycles", 32'(stalls), 32'(v.exp_stall));
    check("done_ctl", 32'(ctl()), 32'({4'b0001, 1'b1, v.exp_write}));
    check("done_pw_rd", 32'(md_if.PW_rd), 32'(v.exp_rd));
    check("done_pw_data", md_if.PW_data, v.exp_data);
    prev_rd   = v.exp_rd;
    prev_data = v.exp_data;
  endtask

  initial begin
    reset_n            = 1'b1;
    md_if.DX_IR        = 32'h0;
    md_if.md_resultRDY = 1'b0;
    md_if.md_exception = 1'b0;
    md_if.md_result    = 32'h0;
    prev_rd            = 5'd0;
    prev_data          = 32'h0;

    //        div rd     k   exc ea  no  res           gap ir            stall wr rd     data
    vecs[0] = mk(0, 5'd3,  5,  0, 0, 0, 32'h0000_0042, 2, 32'h0000_0020, 6,  1, 5'd3,  32'h0000_0042);
    vecs[1] = mk(1, 5'd7,  33, 1, 0, 0, 32'hFFFF_FFFF, 1, 32'h2800_0018, 34, 1, 5'd30, 32'h0000_0005);
    vecs[2] = mk(0, 5'd10, 2,  0, 0, 0, 32'h0000_1111, 1, 32'h0000_0000, 3,  1, 5'd10, 32'h0000_1111);
    vecs[3] = mk(1, 5'd11, 2,  0, 0, 0, 32'h0000_2222, 0, 32'h0000_0000, 3,  1, 5'd11, 32'h0000_2222);
    vecs[4] = mk(0, 5'd0,  1,  0, 0, 0, 32'h0000_0099, 0, 32'h0000_0000, 2,  0, 5'd0,  32'h0000_0099);
    vecs[5] = mk(1, 5'd5,  40, 0, 0, 0, 32'h0000_1234, 1, 32'h00C4_0000, 41, 1, 5'd5,  32'h0000_1234);
    vecs[6] = mk(0, 5'd12, 3,  0, 1, 1, 32'h0000_CAFE, 0, 32'h0000_0000, 4,  1, 5'd12, 32'h0000_CAFE);
    vecs[7] = mk(0, 5'd0,  3,  1, 0, 0, 32'h0000_7777, 1, 32'h0000_0000, 4,  1, 5'd30, 32'h0000_0004);
    vecs[8] = mk(1, 5'd31, 4,  1, 0, 0, 32'h0000_8888, 0, 32'h0000_0000, 5,  1, 5'd30, 32'h0000_0005);
    vecs[9] = mk(0, 5'd4,  0,  0, 0, 0, 32'h0000_0000, 1, 32'h0000_0000, 41, 1, 5'd30, 32'h0000_0004);

    #2 reset_n = 1'b0;
    #1;
    check("reset_ctl", 32'(ctl()), 32'h0);
    check("reset_pw_rd", 32'(md_if.PW_rd), 32'h0);
    check("reset_pw_data", md_if.PW_data, 32'h0);
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i]);
    end

    // Late RDY after the timeout completion must not disturb IDLE or the PW registers.
    @(posedge clock); #1;
    md_if.DX_IR        = 32'h0;
    md_if.md_resultRDY = 1'b1;
    md_if.md_exception = 1'b1;
    md_if.md_result    = 32'hDEAD_BEEF;
    #1;
    check("late_rdy_ctl", 32'(ctl()), 32'h0);
    @(posedge clock); #1;
    md_if.md_resultRDY = 1'b0;
    md_if.md_exception = 1'b0;
    #1;
    check("late_rdy_after_ctl", 32'(ctl()), 32'h0);
    check("late_rdy_pw_rd", 32'(md_if.PW_rd), 32'd30);
    check("late_rdy_pw_data", md_if.PW_data, 32'h0000_0004);

    // Reset asserted in BUSY cycle 3 with the mul still held in DX.
    @(posedge clock); #1;
    md_if.DX_IR = enc(1'b0, 5'd6);
    #1;
    check("rst_issue_ctl", 32'(ctl()), 32'h0000_002C);
    for (int j = 1; j <= 3; j++) begin
      @(posedge clock); #1;
    end
    check("rst_busy3_ctl", 32'(ctl()), 32'h0000_000E);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctl", 32'(ctl()), 32'h0);
    check("rst_mid_pw_rd", 32'(md_if.PW_rd), 32'h0);
    check("rst_mid_pw_data", md_if.PW_data, 32'h0);
    @(posedge clock); #1;
    md_if.DX_IR = 32'h0;
    reset_n     = 1'b1;
    @(posedge clock); #1;
    md_if.md_resultRDY = 1'b1;
    md_if.md_result    = 32'h5555_5555;
    #1;
    check("rst_stale_rdy_ctl", 32'(ctl()), 32'h0);
    @(posedge clock); #1;
    md_if.md_resultRDY = 1'b0;
    #1;
    check("rst_after_ctl", 32'(ctl()), 32'h0);
    check("rst_after_pw_rd", 32'(md_if.PW_rd), 32'h0);
    check("rst_after_pw_data", md_if.PW_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Pipeline controller for the multi-cycle multiplier/divider. Detects a `mul`/`div` in the DX latch, issues the one-cycle start pulse to the multdiv unit, and stalls PC/FD/DX while bubbling XM until the result is ready. It then drives a private writeback port (PW) that writes the result, or the exception code into r30. It sits beside the load-use stall unit; the two stall outputs are ORed by the pipeline.

## Interface
- `TIMEOUT`, 40: maximum BUSY cycles before the unit is declared hung.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `DX_IR`  in  32  instruction in the DX latch; nop = 32'b0.
- `md_resultRDY`  in  1  multdiv result-valid pulse.
- `md_exception`  in  1  multdiv overflow/div-by-zero; meaningful only with `md_resultRDY`.
- `md_result`  in  32  multdiv result.
- `ctrl_MULT`  out  1  start-multiply pulse.
- `ctrl_DIV`  out  1  start-divide pulse.
- `md_stall`  out  1  hold PC, FD and DX.
- `md_bubble`  out  1  load nop into XM instead of DX contents.
- `md_busy`  out  1  state != IDLE.
- `PW_write`  out  1  one-cycle regfile write enable.
- `PW_rd`  out  5  destination register, registered.
- `PW_data`  out  32  write data, registered.

## Operation
- Decode: md op when `DX_IR[31:27]==5'b00000` and `DX_IR[6:2]` is 5'b00110 (mul) or 5'b00111 (div). rd = `DX_IR[26:22]`.
- States: IDLE, BUSY, DONE.
- IDLE, md op in DX:
  - `ctrl_MULT` or `ctrl_DIV` = 1, combinational, this cycle only.
  - `md_stall` = 1 and `md_bubble` = 1.
  - Latch rd and the op type. Clear the counter. Go to BUSY.
- IDLE, no md op: all control outputs 0. `md_resultRDY` is ignored.
- BUSY:
  - `md_stall` = `md_bubble` = 1.
  - The counter increments each cycle; it is 1 in the first BUSY cycle.
  - On `md_resultRDY`: register `PW_data`/`PW_rd` and go to DONE.
    - No exception: `PW_data` = `md_result`, `PW_rd` = latched rd.
    - `md_exception`: `PW_rd` = 30, `PW_data` = 4 (mul) or 5 (div).
  - Timeout: when counter == `TIMEOUT` without RDY, take the exception path. RDY wins over a simultaneous timeout.
- DONE (one cycle):
  - `md_stall` = 0 and `md_bubble` = 1, so DX advances and the md op never reaches XM.
  - `PW_write` = 1, except when the non-exception `PW_rd` == 0.
  - Go to IDLE. An md op arriving in DX next cycle is issued normally.
- `PW_rd`/`PW_data` hold their values after DONE until the next completion; they also feed the bypass network.
- The regfile must be write-through for the PW port, so an FD instruction stalled behind the md op reads the new value in DONE.
- Counter width is clog2(`TIMEOUT`+1). It saturates and never wraps.

## Timing
- Reset (async, any state): state IDLE, counter 0, `PW_rd` = 0, `PW_data` = 0, all control outputs 0. An in-flight multdiv result is discarded.
- Issue at cycle T with RDY at T+k (k ≥ 1):
  - `md_stall` is high for T..T+k, i.e. k+1 cycles.
  - DONE and `PW_write` occur at T+k+1.
- RDY in the issue cycle itself is ignored.
- Timeout: DONE at T+`TIMEOUT`+1.
- `md_exception` without `md_resultRDY` is ignored.

## Structure
- Shared package:
  - opcode/ALU-op constants (R-type 00000, MUL 00110, DIV 00111);
  - exception codes (MUL_EXC 4, DIV_EXC 5);
  - the r30 (rstatus) index;
  - the state enum.
- One sub-module: `md_timeout_counter` (clear, enable, saturate, `hit` at `TIMEOUT`).

## Test plan
- **Mul, rd=3:** mul in DX, RDY after 5 cycles with result 0x0000_0042 -> `ctrl_MULT` 1 for one cycle; `md_stall` high 6 cycles; DONE with `PW_write`=1, `PW_rd`=3, `PW_data`=0x42.
- **Div by zero, rd=7:** div with RDY+exception after 33 cycles -> `PW_rd`=30, `PW_data`=5; the md op never appears in XM.
- **Hang:** mul with no RDY and `TIMEOUT`=40 -> DONE at T+41 with `PW_rd`=30, `PW_data`=4; a late RDY afterwards in IDLE is ignored.
- **Back-to-back:** mul then div, each RDY at k=2 -> two issues separated by DONE and IDLE; two `PW_write` pulses with the correct rd each.
- **rd=0:** mul with rd=0 and no exception -> `PW_write` stays 0; the stall sequence is otherwise identical.
- **Reset mid-op:** `reset_n` low during BUSY cycle 3 -> all outputs 0 immediately; after release, IDLE with no `PW_write`.
